// File: rtl/seq_onehot_decoder.sv
// Registered binary-to-one-hot decoder with a valid/ready input handshake.
// Level mode holds the decoded line; pulse mode drives it for PULSE_CYCLES cycles.
module seq_onehot_decoder #(
    parameter int unsigned IN_WIDTH     = 4,
    parameter int unsigned PULSE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      binary_in,
    output logic [(1<<IN_WIDTH)-1:0] decoder_out,
    output logic                     out_valid
);

    localparam int unsigned OUT_WIDTH = 1 << IN_WIDTH;
    localparam int unsigned CNT_W     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [OUT_WIDTH-1:0]   decoder_out_q;
    logic                   out_valid_q;
    logic                   last_c;
    logic                   accept_c;

    // The final pulse cycle reopens the input so pulse trains run back-to-back.
    always_comb begin
        last_c   = (cnt_q == CNT_LAST);
        in_ready = enable && ((state_q != PULSE) || last_c);
        accept_c = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            decoder_out_q <= '0;
            out_valid_q   <= 1'b0;
        end else if (accept_c) begin
            state_q       <= mode ? PULSE : HOLD;
            cnt_q         <= '0;
            decoder_out_q <= OUT_WIDTH'(1) << binary_in;
            out_valid_q   <= 1'b1;
        end else begin
            case (state_q)
                PULSE: begin
                    if (last_c) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        decoder_out_q <= '0;
                        out_valid_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD:    ;
                default: ;
            endcase
        end
    end

    assign decoder_out = decoder_out_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Self-checking bench: two decoder configurations against a cycle-level
// reference built from "remaining high cycles" rather than FSM states.
module tb_seq_onehot_decoder;

    localparam int unsigned P0 = 3;
    localparam int unsigned P1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en   [2];
    logic        md   [2];
    logic        vld  [2];
    logic [7:0]  bin  [2];
    logic        rdy0, rdy1;
    logic        ov0, ov1;
    logic [15:0] dout0;
    logic [3:0]  dout1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference: left = 0 idle, -1 held indefinitely, >0 high cycles still to show.
    int         m_left [2] = '{0, 0};
    logic [7:0] m_code [2] = '{8'd0, 8'd0};

    always #5 clk = ~clk;

    seq_onehot_decoder #(.IN_WIDTH(4), .PULSE_CYCLES(P0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .mode(md[0]), .in_valid(vld[0]),
        .in_ready(rdy0), .binary_in(bin[0][3:0]), .decoder_out(dout0), .out_valid(ov0)
    );

    seq_onehot_decoder #(.IN_WIDTH(2), .PULSE_CYCLES(P1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .mode(md[1]), .in_valid(vld[1]),
        .in_ready(rdy1), .binary_in(bin[1][1:0]), .decoder_out(dout1), .out_valid(ov1)
    );

    function automatic bit model_ready(int i);
        return en[i] && (m_left[i] <= 1);
    endfunction

    function automatic logic [31:0] model_out(int i);
        return (m_left[i] != 0) ? (32'd1 << m_code[i]) : 32'd0;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit r;
            r = model_ready(i);
            if (rst || !en[i]) begin
                m_left[i] = 0;
            end else if (vld[i] && r) begin
                m_code[i] = bin[i];
                m_left[i] = md[i] ? ((i == 0) ? int'(P0) : int'(P1)) : -1;
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all();
        chk("dout0", 32'(dout0), model_out(0));
        chk("ov0", 32'(ov0), 32'(model_out(0) != 0));
        chk("rdy0", 32'(rdy0), 32'(model_ready(0)));
        chk("onehot0_0", 32'($onehot0(dout0)), 32'd1);
        chk("dout1", 32'(dout1), model_out(1));
        chk("ov1", 32'(ov1), 32'(model_out(1) != 0));
        chk("rdy1", 32'(rdy1), 32'(model_ready(1)));
        chk("onehot0_1", 32'($onehot0(dout1)), 32'd1);
    endtask

    task automatic directed();
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b1; md[i] = 1'b0; vld[i] = 1'b0; bin[i] = 8'd0;
        end
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_dout", 32'(dout0), 32'h0);
        chk("reset_ov", 32'(ov0), 32'h0);
        chk("reset_rdy", 32'(rdy0), 32'h1);

        // Level mode hold and replace without a gap
        bin[0] = 8'hA; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("lvl_A", 32'(dout0), 32'h0400);
        chk("lvl_A_ov", 32'(ov0), 32'h1);
        for (int k = 0; k < 11; k++) step();
        chk("lvl_A_held", 32'(dout0), 32'h0400);
        bin[0] = 8'h3; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("lvl_3", 32'(dout0), 32'h0008);

        // Exhaustive back-to-back sweep
        vld[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bin[0] = 8'(c);
            step();
            chk("sweep", 32'(dout0), 32'd1 << c);
        end
        vld[0] = 1'b0;

        // Single pulse of three cycles
        md[0] = 1'b1; bin[0] = 8'h5; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("p5_c1", 32'(dout0), 32'h0020);
        chk("p5_c1_rdy", 32'(rdy0), 32'h0);
        step();
        chk("p5_c2", 32'(dout0), 32'h0020);
        chk("p5_c2_rdy", 32'(rdy0), 32'h0);
        step();
        chk("p5_c3", 32'(dout0), 32'h0020);
        chk("p5_c3_rdy", 32'(rdy0), 32'h1);
        step();
        chk("p5_end", 32'(dout0), 32'h0);
        chk("p5_end_ov", 32'(ov0), 32'h0);

        // Contiguous pulse train; busy-cycle valid is not captured
        bin[0] = 8'h1; vld[0] = 1'b1;
        step();
        bin[0] = 8'hF;
        chk("p1_c1", 32'(dout0), 32'h0002);
        step();
        chk("p1_c2", 32'(dout0), 32'h0002);
        step();
        chk("p1_c3", 32'(dout0), 32'h0002);
        step();
        vld[0] = 1'b0;
        chk("pF_c1", 32'(dout0), 32'h8000);
        step();
        chk("pF_c2", 32'(dout0), 32'h8000);
        step();
        chk("pF_c3", 32'(dout0), 32'h8000);
        step();
        chk("pF_end", 32'(dout0), 32'h0);

        // Abort by enable mid-pulse
        bin[0] = 8'h2; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        step();
        en[0] = 1'b0;
        chk("en_low_rdy", 32'(rdy0), 32'h0);
        step();
        chk("en_abort", 32'(dout0), 32'h0);
        en[0] = 1'b1;
        step();
        chk("en_abort_stay", 32'(dout0), 32'h0);

        // Abort by reset during hold
        md[0] = 1'b0; bin[0] = 8'h8; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("hold_8", 32'(dout0), 32'h0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_abort", 32'(dout0), 32'h0);
        chk("rst_abort_ov", 32'(ov0), 32'h0);
        chk("rst_rdy", 32'(rdy0), 32'h1);

        // Narrow instance, one-cycle pulses back-to-back
        md[1] = 1'b1; vld[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bin[1] = 8'(c);
            step();
            chk("n_pulse", 32'(dout1), 32'd1 << c);
            chk("n_rdy", 32'(rdy1), 32'h1);
        end
        vld[1] = 1'b0;
        step();
        chk("n_end", 32'(dout1), 32'h0);
        chk("n_end_ov", 32'(ov1), 32'h0);
    endtask

    task automatic random_phase();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                en[i]  = ($urandom_range(0, 19) != 0);
                md[i]  = 1'($urandom);
                vld[i] = ($urandom_range(0, 2) != 0);
                bin[i] = (i == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 3));
            end
            step();
        end
    endtask

    initial begin
        fork
            begin
                directed();
                random_phase();
            end
            forever begin
                @(negedge clk);
                if (chk_en) compare_all();
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
